// File: rtl/fetch_pkg.sv
// Shared widths and the buffered fetch entry for the instruction fetch stage.
//   PC_W        : PC / byte-address width
//   INSTR_W     : instruction width
//   INSTR_BYTES : bytes per instruction word (sequential PC increment)
//   DEPTH       : fetch buffer entries (fixed at 2)
//   CNT_W       : width of the buffer occupancy count
package fetch_pkg;

    localparam int unsigned PC_W        = 64;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned DEPTH       = 2;
    localparam int unsigned CNT_W       = 2;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of fetched instructions.
//   clk, reset  : clock, synchronous active-high reset
//   push        : append push_entry at the tail
//   pop         : remove the head
//   flush_tail  : discard every entry behind the head (applied before pop)
//   head        : head entry (meaningful when count != 0)
//   count       : occupancy, 0..2
module fetch_buf
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush_tail,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     entry0_q, entry0_d;
    fetch_entry_t     entry1_q, entry1_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next state: flush the tail first so a redirect-with-pop empties the buffer.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;

        if (flush_tail && (count_d > CNT_W'(1))) begin
            count_d = CNT_W'(1);
        end

        if (pop && (count_d != '0)) begin
            entry0_d = entry1_q;
            count_d  = count_d - CNT_W'(1);
        end

        if (push) begin
            if (count_d == '0) begin
                entry0_d = push_entry;
            end else begin
                entry1_d = push_entry;
            end
            count_d = count_d + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one-outstanding word reads to
// instruction memory, buffers up to two returned instructions and redirects on
// taken branches, squashing any wrong-path response still in flight.
//   CLK, reset          : clock, synchronous active-high reset
//   startpc             : PC loaded during reset (low two bits ignored)
//   imem_req/imem_addr  : one-cycle read request and its byte address
//   imem_rvalid/rdata   : read response (at least one cycle after the request)
//   instr_valid/instr   : buffer head valid and instruction
//   currentpc           : PC of the head (reset PC while the buffer is empty)
//   instr_ready         : datapath consumes the head this cycle
//   br_taken/br_offset  : with a consume, branch taken and signed word offset
module instr_fetch_unit
    import fetch_pkg::*;
(
    input  logic               CLK,
    input  logic               reset,
    input  logic [PC_W-1:0]    startpc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    currentpc,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_offset
);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic [PC_W-1:0]  start_pc_q;
    logic             outstanding_q, outstanding_d;
    logic             squash_q, squash_d;

    fetch_entry_t     buf_head;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] count_next;
    logic             fire;
    logic             redirect;
    logic             rsp;
    logic             push;
    logic [PC_W-1:0]  target;

    assign instr_valid = (buf_count != '0);
    assign currentpc   = instr_valid ? buf_head.pc : start_pc_q;
    assign instr       = instr_valid ? buf_head.instr : '0;

    assign fire     = instr_valid & instr_ready;
    assign redirect = fire & br_taken;
    assign target   = currentpc + (br_offset << 2);

    // A response is dropped if squashed or if a redirect lands in the same cycle.
    assign rsp        = imem_rvalid & outstanding_q;
    assign push       = rsp & ~squash_q & ~redirect;
    assign push_entry = {req_pc_q, imem_rdata};

    // Occupancy after this cycle decides whether there is room for another fetch.
    assign count_next = redirect ? '0
                                 : CNT_W'(buf_count + CNT_W'(push) - CNT_W'(fire));

    assign imem_req  = ~reset & ~outstanding_q & (count_next < CNT_W'(DEPTH));
    assign imem_addr = redirect ? target : fetch_pc_q;

    // Fetch control next state.
    always_comb begin
        fetch_pc_d    = imem_addr;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        squash_d      = squash_q;

        if (imem_req) begin
            fetch_pc_d    = imem_addr + PC_W'(INSTR_BYTES);
            req_pc_d      = imem_addr;
            outstanding_d = 1'b1;
        end else if (rsp) begin
            outstanding_d = 1'b0;
        end

        if (rsp) begin
            squash_d = 1'b0;
        end else if (redirect && outstanding_q) begin
            squash_d = 1'b1;
        end
    end

    // Fetch control state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_pc_q    <= startpc & ~PC_W'(INSTR_BYTES - 1);
            start_pc_q    <= startpc & ~PC_W'(INSTR_BYTES - 1);
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            squash_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
        end
    end

    fetch_buf u_buf (
        .clk        (CLK),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (fire),
        .flush_tail (redirect),
        .head       (buf_head),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency memory responder
// and a scoreboard of expected head PCs.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic [63:0] startpc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] currentpc;
    logic        instr_ready;
    logic        br_taken;
    logic [63:0] br_offset;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] req_log[$];
    logic [63:0] exp_q[$];

    instr_fetch_unit dut (
        .CLK         (CLK),
        .reset       (reset),
        .startpc     (startpc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .currentpc   (currentpc),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_offset   (br_offset)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory: a request seen at an edge is answered mem_lat cycles later.
    always @(posedge CLK) begin : responder
        logic        req_now;
        logic [63:0] addr_now;
        req_now  = imem_req;
        addr_now = imem_addr;
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        if (req_now) begin
            pend_q.push_back('{cyc + mem_lat - 1, addr_now});
            req_log.push_back(addr_now);
        end
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Long enough reset for any in-flight response to drain.
    task automatic do_reset(input logic [63:0] spc);
        @(negedge CLK);
        reset       = 1'b1;
        startpc     = spc;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        repeat (5) @(negedge CLK);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_req",   64'(imem_req),    64'd0);
        check("rst_pc",    currentpc,        {spc[63:2], 2'b00});
        check("rst_instr", 64'(instr),       64'd0);
        exp_q.delete();
        exp_q.push_back({spc[63:2], 2'b00});
        req_log.delete();
        reset = 1'b0;
    endtask

    // Wait for a head, optionally hold it `pre` cycles, check it, consume it.
    task automatic consume(input string tag, input bit br, input logic [63:0] off, input int pre);
        int          w;
        logic [63:0] exp_pc;
        w = 0;
        while (instr_valid !== 1'b1 && w < 40) begin
            @(negedge CLK);
            w++;
        end
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        repeat (pre) @(negedge CLK);
        exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check({tag, "_pc"},    currentpc,   exp_pc);
        check({tag, "_instr"}, 64'(instr),  64'(mem_data(exp_pc)));
        instr_ready = 1'b1;
        br_taken    = br;
        br_offset   = off;
        exp_q.delete();
        exp_q.push_back(br ? exp_pc + (off << 2) : exp_pc + 64'd4);
        @(negedge CLK);
        instr_ready = 1'b0;
        br_taken    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        startpc     = 64'h40;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        br_offset   = 64'h0;

        // Sequential fetch from 0x40 with 1-cycle memory.
        mem_lat = 1;
        do_reset(64'h40);
        consume("t1a", 1'b0, 64'h0, 0);
        consume("t1b", 1'b0, 64'h0, 0);
        consume("t1c", 1'b0, 64'h0, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_addr%0d", i),
                  (i < req_log.size()) ? req_log[i] : '1, 64'h40 + 64'(4 * i));
        end

        // Stalled consumer: buffer fills to 2, then requests stop.
        do_reset(64'h80);
        repeat (10) @(negedge CLK);
        check("t2_nreq",  64'(req_log.size()),  64'd2);
        check("t2_count", 64'(dut.u_buf.count), 64'd2);
        check("t2_idle",  64'(imem_req),        64'd0);
        consume("t2a", 1'b0, 64'h0, 0);
        consume("t2b", 1'b0, 64'h0, 0);

        // Backward branch from 0x10 with the tail entry 0x14 dropped.
        do_reset(64'h10);
        repeat (6) @(negedge CLK);
        check("t3_count", 64'(dut.u_buf.count), 64'd2);
        consume("t3_br",  1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        consume("t3_tgt", 1'b0, 64'h0, 0);
        consume("t3_seq", 1'b0, 64'h0, 0);

        // Redirect while a 3-cycle request for 0x104 is outstanding.
        mem_lat = 3;
        do_reset(64'h100);
        consume("t4_br",  1'b1, 64'd8, 1);
        consume("t4_tgt", 1'b0, 64'h0, 0);
        consume("t4_seq", 1'b0, 64'h0, 0);
        check("t4_sq_addr",  (req_log.size() > 1) ? req_log[1] : '1, 64'h104);
        check("t4_tgt_addr", (req_log.size() > 2) ? req_log[2] : '1, 64'h120);

        // Reset during an outstanding request; its late response must be ignored.
        mem_lat = 2;
        do_reset(64'h40);
        @(negedge CLK);
        reset   = 1'b1;
        startpc = 64'h200;
        @(negedge CLK);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(64'h200);
        #1;
        check("t5_req",   64'(imem_req),    64'd1);
        check("t5_addr",  imem_addr,        64'h200);
        check("t5_pc",    currentpc,        64'h200);
        check("t5_valid", 64'(instr_valid), 64'd0);
        consume("t5a", 1'b0, 64'h0, 0);
        consume("t5b", 1'b0, 64'h0, 0);

        // Wrap past the top of the address space (branch and increment).
        mem_lat = 1;
        do_reset(64'hFFFF_FFFF_FFFF_FFFB);
        consume("t6_br",   1'b1, 64'd2, 0);
        consume("t6_wrap", 1'b0, 64'h0, 0);
        consume("t6_seq",  1'b0, 64'h0, 0);
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        consume("t6_inc_a", 1'b0, 64'h0, 0);
        consume("t6_inc_b", 1'b0, 64'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
